context_restore: RTL and testbench

- Reads a process context frame back out of data memory and replays it into the processor state. It is the inverse of the RAM snapshot path.
- Frame layout at base = Proc_ID*256:
  - words 0..63: register bank, register i at offset i.
  - words 64..71: seven-segment displays 0..7, each value in bits [6:0], bits [31:7] zero.
- Sits between the scheduler, which issues Start, and the memory read port, register-bank write port, display latches and PC-update logic.
- Streams one word per cycle, pipelined against the memory read latency.

---
 rtl/context_restore_pkg.sv | 22 ++
 rtl/context_restore_read_pipe.sv | 43 ++++
 rtl/context_restore.sv | 147 ++++++++++++++
 tb/tb_context_restore.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/context_restore_pkg.sv
// Frame layout constants and FSM encoding shared by the context save and restore paths.
package context_restore_pkg;

    localparam int FRAME_STRIDE = 256;
    localparam int NUM_REGS     = 64;
    localparam int NUM_DISP     = 8;
    localparam int DISP_OFFSET  = NUM_REGS;
    localparam int FRAME_WORDS  = NUM_REGS + NUM_DISP;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Word offset of a process frame; callers truncate to their address width.
    function automatic int frame_offset(input logic [1:0] proc_id, input int stride);
        return int'(proc_id) * stride;
    endfunction

endpackage

// File: rtl/context_restore_read_pipe.sv
// Delays each issued word index by the memory read latency so the return stage
// knows which frame word the current Read_Data belongs to.
module context_restore_read_pipe
    import context_restore_pkg::*;
#(
    parameter int               LATENCY  = 1,
    parameter int               IDX_W    = $clog2(FRAME_WORDS),
    parameter logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_idx,
    output logic             ret_valid,
    output logic [IDX_W-1:0] ret_idx,
    output logic             ret_last
);

    logic [LATENCY-1:0] valid_sr;
    logic [IDX_W-1:0]   idx_sr [LATENCY];

    // A reset drops every tag, so reads still in flight are never written back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                idx_sr[s] <= '0;
            end
        end else begin
            valid_sr[0] <= issue_valid;
            idx_sr[0]   <= issue_idx;
            for (int s = 1; s < LATENCY; s++) begin
                valid_sr[s] <= valid_sr[s-1];
                idx_sr[s]   <= idx_sr[s-1];
            end
        end
    end

    assign ret_valid = valid_sr[LATENCY-1];
    assign ret_idx   = idx_sr[LATENCY-1];
    assign ret_last  = ret_valid && (idx_sr[LATENCY-1] == LAST_IDX);

endmodule

// File: rtl/context_restore.sv
// Replays a saved process frame from data memory into the register bank and the
// seven-segment display latches, one word per cycle, then pulses Done/Update_PC.
module context_restore #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int FRAME_STRIDE = context_restore_pkg::FRAME_STRIDE,
    parameter int NUM_REGS     = context_restore_pkg::NUM_REGS,
    parameter int NUM_DISP     = context_restore_pkg::NUM_DISP,
    parameter int READ_LATENCY = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Proc_ID,
    input  logic [DATA_WIDTH-1:0] Read_Data,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic                  Mem_Read,
    output logic                  Reg_Write,
    output logic [5:0]            Reg_Addr,
    output logic [DATA_WIDTH-1:0] Reg_Data,
    output logic                  Disp_Write,
    output logic [2:0]            Disp_Sel,
    output logic [6:0]            Disp_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Update_PC,
    output logic                  Frame_Error
);

    import context_restore_pkg::*;

    localparam int               WORDS     = NUM_REGS + NUM_DISP;
    localparam int               IDX_W     = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] REG_LIMIT = IDX_W'(NUM_REGS);

    state_t                  state;
    state_t                  next_state;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   frame_base;
    logic [IDX_W-1:0]        issue_idx;
    logic                    ret_valid;
    logic [IDX_W-1:0]        ret_idx;
    logic                    ret_last;
    logic                    last_emitted;

    assign accept     = (state == ST_IDLE) && Start;
    assign frame_base = ADDR_WIDTH'(frame_offset(Proc_ID, FRAME_STRIDE));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DRAIN waits for the strobe of the final word, not its issue, so any
    // read latency is absorbed without a separate counter.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (Start) next_state = ST_ISSUE;
            ST_ISSUE: if (issue_idx == LAST_IDX) next_state = ST_DRAIN;
            ST_DRAIN: if (last_emitted) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Issue side: the address register is loaded with the frame base on accept
    // and walks forward; it holds the final address once issuing stops.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Mem_Address <= '0;
            Mem_Read    <= 1'b0;
            issue_idx   <= '0;
        end else if (accept) begin
            Mem_Address <= frame_base;
            Mem_Read    <= 1'b1;
            issue_idx   <= '0;
        end else if (state == ST_ISSUE) begin
            if (issue_idx == LAST_IDX) begin
                Mem_Read <= 1'b0;
            end else begin
                Mem_Address <= Mem_Address + ADDR_WIDTH'(1);
                issue_idx   <= issue_idx + IDX_W'(1);
            end
        end
    end

    context_restore_read_pipe #(
        .LATENCY  (READ_LATENCY),
        .IDX_W    (IDX_W),
        .LAST_IDX (LAST_IDX)
    ) u_read_pipe (
        .clk         (Clock),
        .rst         (Reset),
        .issue_valid (Mem_Read),
        .issue_idx   (issue_idx),
        .ret_valid   (ret_valid),
        .ret_idx     (ret_idx),
        .ret_last    (ret_last)
    );

    // Return side: each tagged word becomes exactly one registered strobe,
    // routed to the register bank or a display latch by its frame index.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Reg_Write    <= 1'b0;
            Reg_Addr     <= '0;
            Reg_Data     <= '0;
            Disp_Write   <= 1'b0;
            Disp_Sel     <= '0;
            Disp_Data    <= '0;
            Frame_Error  <= 1'b0;
            last_emitted <= 1'b0;
        end else begin
            Reg_Write    <= 1'b0;
            Disp_Write   <= 1'b0;
            last_emitted <= 1'b0;
            if (accept) begin
                Frame_Error <= 1'b0;
            end
            if (ret_valid) begin
                last_emitted <= ret_last;
                if (ret_idx < REG_LIMIT) begin
                    Reg_Write <= 1'b1;
                    Reg_Addr  <= 6'(ret_idx);
                    Reg_Data  <= Read_Data;
                end else begin
                    Disp_Write <= 1'b1;
                    Disp_Sel   <= 3'(ret_idx - REG_LIMIT);
                    Disp_Data  <= Read_Data[6:0];
                    if (|Read_Data[DATA_WIDTH-1:7]) begin
                        Frame_Error <= 1'b1;
                    end
                end
            end
        end
    end

    assign Busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign Done      = (state == ST_DONE);
    assign Update_PC = (state == ST_DONE);

endmodule

// File: tb/tb_context_restore.sv
// Directed bench for context_restore: two instances (read latency 1 and 3) share
// stimulus and memory; per-lane monitors score every issue and strobe.
module tb_context_restore;

    localparam int DW = 32;
    localparam int AW = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] proc_id;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [DW-1:0] ram [0:1023];
    int            base;
    logic          arm [2];
    int            t_start [2];
    int            checks = 0;
    int            errors = 0;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [DW-1:0] read_data;
        logic [AW-1:0] mem_address;
        logic          mem_read;
        logic          reg_write;
        logic [5:0]    reg_addr;
        logic [DW-1:0] reg_data;
        logic          disp_write;
        logic [2:0]    disp_sel;
        logic [6:0]    disp_data;
        logic          busy;
        logic          done;
        logic          update_pc;
        logic          frame_error;
        logic [AW-1:0] addr_q [LAT];
        logic [DW-1:0] exp_word;
        logic          exp_fe;
        int n_strobe, bad_strobe, n_addr, bad_addr, n_done, done_cyc, n_busy, bad_misc, bad_fe;

        context_restore #(
            .DATA_WIDTH   (DW),
            .ADDR_WIDTH   (AW),
            .READ_LATENCY (LAT)
        ) dut (
            .Clock       (clock),
            .Reset       (reset),
            .Start       (start),
            .Proc_ID     (proc_id),
            .Read_Data   (read_data),
            .Mem_Address (mem_address),
            .Mem_Read    (mem_read),
            .Reg_Write   (reg_write),
            .Reg_Addr    (reg_addr),
            .Reg_Data    (reg_data),
            .Disp_Write  (disp_write),
            .Disp_Sel    (disp_sel),
            .Disp_Data   (disp_data),
            .Busy        (busy),
            .Done        (done),
            .Update_PC   (update_pc),
            .Frame_Error (frame_error)
        );

        // Memory model: data for an address appears LAT cycles after it is driven.
        always @(posedge clock) begin
            addr_q[0] <= mem_address;
            for (int k = 1; k < LAT; k++) addr_q[k] <= addr_q[k-1];
        end
        assign read_data = ram[addr_q[LAT-1][9:0]];

        // Scoreboard: expected address, strobe content and cycle come from the frame layout.
        always @(negedge clock) begin
            if (arm[g]) begin
                n_strobe = 0; bad_strobe = 0; n_addr = 0; bad_addr = 0;
                n_done = 0; done_cyc = 0; n_busy = 0; bad_misc = 0; bad_fe = 0;
                exp_fe = 1'b0;
            end else begin
                if (mem_read) begin
                    if (mem_address !== AW'(base + n_addr) || cyc != t_start[g] + 1 + n_addr) bad_addr++;
                    n_addr++;
                end
                if (reg_write || disp_write) begin
                    exp_word = ram[10'(base + n_strobe)];
                    if (n_strobe < 64) begin
                        if (!(reg_write && !disp_write && reg_addr == 6'(n_strobe) && reg_data === exp_word)) bad_strobe++;
                    end else begin
                        if (!(disp_write && !reg_write && disp_sel == 3'(n_strobe - 64) && disp_data === exp_word[6:0])) bad_strobe++;
                        if (exp_word[31:7] != 25'd0) exp_fe = 1'b1;
                    end
                    if (cyc != t_start[g] + 2 + n_strobe + LAT) bad_strobe++;
                    n_strobe++;
                end
                if ((busy || done) && frame_error !== exp_fe) bad_fe++;
                if (busy) n_busy++;
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                if (update_pc !== done || (busy && done) || (reg_write && disp_write)) bad_misc++;
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulses Start for one cycle (or leaves it high when hold is set); returns at T+1.
    task automatic apply_stimulus(input logic [1:0] pid, input bit hold);
        @(posedge clock); #1;
        proc_id = pid;
        start   = 1'b1;
        base    = int'(pid) * 256;
        for (int g = 0; g < 2; g++) begin
            arm[g]     = 1'b1;
            t_start[g] = cyc;
        end
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        for (int g = 0; g < 2; g++) arm[g] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((lane[0].n_done == 0 || lane[1].n_done == 0) && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        check_output("done_timeout", k < budget, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_full(input string tag);
        check_output({tag, "_l0_count"},     lane[0].n_strobe,   72);
        check_output({tag, "_l0_strobes"},   lane[0].bad_strobe, 0);
        check_output({tag, "_l0_addr_n"},    lane[0].n_addr,     72);
        check_output({tag, "_l0_addr_seq"},  lane[0].bad_addr,   0);
        check_output({tag, "_l0_done_n"},    lane[0].n_done,     1);
        check_output({tag, "_l0_done_cyc"},  lane[0].done_cyc,   t_start[0] + 75);
        check_output({tag, "_l0_busy_cyc"},  lane[0].n_busy,     74);
        check_output({tag, "_l0_misc"},      lane[0].bad_misc,   0);
        check_output({tag, "_l0_frame_err"}, lane[0].bad_fe,     0);
        check_output({tag, "_l1_count"},     lane[1].n_strobe,   72);
        check_output({tag, "_l1_strobes"},   lane[1].bad_strobe, 0);
        check_output({tag, "_l1_addr_n"},    lane[1].n_addr,     72);
        check_output({tag, "_l1_addr_seq"},  lane[1].bad_addr,   0);
        check_output({tag, "_l1_done_n"},    lane[1].n_done,     1);
        check_output({tag, "_l1_done_cyc"},  lane[1].done_cyc,   t_start[1] + 77);
        check_output({tag, "_l1_busy_cyc"},  lane[1].n_busy,     76);
        check_output({tag, "_l1_misc"},      lane[1].bad_misc,   0);
        check_output({tag, "_l1_frame_err"}, lane[1].bad_fe,     0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        proc_id = 2'd0;
        base    = 0;
        for (int g = 0; g < 2; g++) begin
            arm[g]     = 1'b0;
            t_start[g] = 0;
        end
        for (int k = 0; k < 1024; k++) ram[k] = '0;
        for (int k = 0; k < 64; k++) begin
            ram[k]         = 32'h0000_1000 + k;
            ram[256 + k]   = 32'hA5A5_0000 + k;
            ram[512 + k]   = 32'hFFFF_FF00 + k;
            ram[768 + k]   = 32'h0000_3000 + k;
        end
        for (int d = 0; d < 8; d++) begin
            ram[64 + d]  = d + 1;
            ram[320 + d] = d + 1;
            ram[576 + d] = 32'h7F - d;
            ram[832 + d] = 32'h40 + d;
        end
        ram[256 + 66] = 32'h0000_0080;

        repeat (2) @(posedge clock);
        #1;
        check_output("reset_ctrl", {lane[0].mem_address, lane[0].mem_read, lane[0].reg_write, lane[0].reg_addr,
                     lane[0].disp_write, lane[0].disp_sel, lane[0].disp_data, lane[0].busy, lane[0].done,
                     lane[0].update_pc, lane[0].frame_error}, 0);
        check_output("reset_data", lane[0].reg_data, 0);
        reset = 1'b0;

        $display("[TB] frame 0, both latencies");
        apply_stimulus(2'd0, 1'b0);
        wait_done(200);
        check_full("p0");
        check_output("p0_addr_hold", {lane[0].mem_read, lane[0].mem_address}, {1'b0, 16'h0047});
        check_output("p0_frame_err", lane[0].frame_error, 0);

        $display("[TB] frame 3 with a stray Start mid-issue");
        apply_stimulus(2'd3, 1'b0);
        check_output("p3_first_addr", {lane[0].mem_read, lane[0].mem_address}, {1'b1, 16'h0300});
        repeat (19) @(posedge clock);
        #1;
        start   = 1'b1;
        proc_id = 2'd1;
        @(posedge clock); #1;
        start   = 1'b0;
        proc_id = 2'd3;
        wait_done(200);
        check_full("p3");
        check_output("p3_last_addr", lane[0].mem_address, 16'h0347);

        $display("[TB] frame 1 with bad display word");
        apply_stimulus(2'd1, 1'b0);
        wait_done(200);
        check_full("p1");
        check_output("p1_fe_l0", lane[0].frame_error, 1);
        check_output("p1_fe_l1", lane[1].frame_error, 1);
        apply_stimulus(2'd0, 1'b0);
        check_output("fe_clear_l0", lane[0].frame_error, 0);
        check_output("fe_clear_l1", lane[1].frame_error, 0);
        wait_done(200);
        check_full("p0b");

        $display("[TB] Start held through restore, reaccepted in first idle cycle");
        apply_stimulus(2'd0, 1'b1);
        repeat (75) @(posedge clock);
        #1;
        check_output("hold_l0_count",   lane[0].n_strobe,   72);
        check_output("hold_l0_strobes", lane[0].bad_strobe, 0);
        check_output("hold_l0_done_n",  lane[0].n_done,     1);
        check_output("hold_l0_done_cyc", lane[0].done_cyc,  t_start[0] + 75);
        check_output("hold_l0_idle",    lane[0].busy,       0);
        arm[0]     = 1'b1;
        t_start[0] = cyc;
        @(posedge clock); #1;
        arm[0] = 1'b0;
        start  = 1'b0;
        wait_done(200);
        check_output("hold_l1_count",   lane[1].n_strobe,   72);
        check_output("hold_l1_strobes", lane[1].bad_strobe, 0);
        check_output("hold_l1_done_n",  lane[1].n_done,     1);
        check_output("hold_l1_done_cyc", lane[1].done_cyc,  t_start[1] + 77);
        check_output("again_l0_count",  lane[0].n_strobe,   72);
        check_output("again_l0_strobes", lane[0].bad_strobe, 0);
        check_output("again_l0_addr",   lane[0].bad_addr,   0);
        check_output("again_l0_done_n", lane[0].n_done,     1);
        check_output("again_l0_done_cyc", lane[0].done_cyc, t_start[0] + 75);

        $display("[TB] reset during issue of word 30");
        apply_stimulus(2'd2, 1'b0);
        repeat (30) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_output("rst_mid_ctrl", {lane[0].mem_address, lane[0].mem_read, lane[0].reg_write, lane[0].reg_addr,
                     lane[0].disp_write, lane[0].disp_sel, lane[0].disp_data, lane[0].busy, lane[0].done,
                     lane[0].update_pc, lane[0].frame_error}, 0);
        check_output("rst_mid_data", lane[0].reg_data, 0);
        check_output("rst_mid_l1", {lane[1].mem_address, lane[1].mem_read, lane[1].busy}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check_output("rst_l0_strobes", lane[0].n_strobe, 28);
        check_output("rst_l1_strobes", lane[1].n_strobe, 26);
        check_output("rst_done", {lane[0].n_done[7:0], lane[1].n_done[7:0]}, 0);
        apply_stimulus(2'd2, 1'b0);
        wait_done(200);
        check_full("p2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
